// File: rtl/nios_system_cpu_jtag_cmd_sysclk_fifo.sv
// rtl/nios_system_cpu_jtag_cmd_sysclk_fifo.sv - clk-side JTAG command receiver
// The JTAG_CMD_FIFO_EN macro selects a FIFO_DEPTH queue; without it a single holding register.
module nios_system_cpu_jtag_cmd_sysclk_fifo #(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                vs_uir,
  input  logic                                vs_udr,
  input  logic [IR_W-1:0]                     ir_in,
  input  logic [DATA_W-1:0]                   sr,
  input  logic                                cmd_ready,
  input  logic                                overrun_clr,
  output logic                                cmd_valid,
  output logic [DATA_W-1:0]                   jdo,
  output logic [IR_W-1:0]                     cmd_ir,
  output logic [(1<<IR_W)-1:0]                take_action,
  output logic                                ir_update,
  output logic [IR_W-1:0]                     ir_latched,
  output logic                                overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     level
);

  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W  = DATA_W + IR_W;
  localparam int WARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_END = WARM_W'(SYNC_STAGES + 1);
  localparam logic [WARM_W-1:0] WARM_ONE = WARM_W'(1);

  logic [SYNC_STAGES-1:0] uir_sync_q, udr_sync_q;
  logic                   uir_dly_q, udr_dly_q;
  logic [WARM_W-1:0]      warm_q;
  logic                   warm_done;
  logic                   uir_edge, udr_edge;
  logic [IR_W-1:0]        ir_q;
  logic                   ir_update_q;
  logic                   overrun_q, overrun_d;
  logic                   pop, drop;
  logic                   valid_w;
  logic [ENT_W-1:0]       head_w;
  logic [LVL_W-1:0]       level_w;

  // Delay flops keep tracking during warm-up so a strobe held across reset never looks like a rise.
  assign warm_done = (warm_q == WARM_END);
  assign uir_edge  = warm_done & uir_sync_q[SYNC_STAGES-1] & ~uir_dly_q;
  assign udr_edge  = warm_done & udr_sync_q[SYNC_STAGES-1] & ~udr_dly_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_sync_q  <= '0;
      udr_sync_q  <= '0;
      uir_dly_q   <= 1'b0;
      udr_dly_q   <= 1'b0;
      warm_q      <= '0;
      ir_q        <= '0;
      ir_update_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      uir_sync_q  <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_sync_q  <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_dly_q   <= uir_sync_q[SYNC_STAGES-1];
      udr_dly_q   <= udr_sync_q[SYNC_STAGES-1];
      if (!warm_done) warm_q <= warm_q + WARM_ONE;
      ir_update_q <= uir_edge;
      if (uir_edge) ir_q <= ir_in;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (drop)        overrun_d = 1'b1;
  end

`ifdef JTAG_CMD_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FIFO_DEPTH);

  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] count_q;
  logic             full, push;

  assign valid_w = (count_q != '0);
  assign full    = (count_q == LVL_MAX);
  assign pop     = valid_w & cmd_ready;
  // When full, a same-cycle pop frees the slot the write pointer already addresses.
  assign push    = udr_edge & (~full | pop);
  assign drop    = udr_edge & full & ~pop;
  assign head_w  = mem_q[rd_ptr_q];
  assign level_w = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {ir_q, sr};
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_q <= count_q + LVL_ONE;
      else if (pop && !push) count_q <= count_q - LVL_ONE;
    end
  end
`else
  logic [ENT_W-1:0] hold_q;
  logic             hold_valid_q;

  assign valid_w = hold_valid_q;
  assign pop     = hold_valid_q & cmd_ready;
  assign drop    = udr_edge & hold_valid_q & ~cmd_ready;
  assign head_w  = hold_q;
  assign level_w = LVL_W'(hold_valid_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else if (udr_edge) begin
      hold_q       <= {ir_q, sr};
      hold_valid_q <= 1'b1;
    end else if (pop) begin
      hold_valid_q <= 1'b0;
    end
  end
`endif

  assign cmd_valid        = valid_w;
  assign {cmd_ir, jdo}    = valid_w ? head_w : '0;
  assign ir_update        = ir_update_q;
  assign ir_latched       = ir_q;
  assign overrun          = overrun_q;
  assign level            = level_w;

  always_comb begin
    take_action = '0;
    if (pop) take_action[cmd_ir] = 1'b1;
  end

endmodule

// File: tb/tb_nios_system_cpu_jtag_cmd_sysclk_fifo.sv
// tb/tb_nios_system_cpu_jtag_cmd_sysclk_fifo.sv - directed vector bench for the JTAG command receiver
module tb_nios_system_cpu_jtag_cmd_sysclk_fifo;

`ifdef JTAG_CMD_FIFO_EN
  localparam int DEPTH_EFF = 4;
`else
  localparam int DEPTH_EFF = 1;
`endif

  localparam int OP_PUSH = 0;
  localparam int OP_POP  = 1;
  localparam int OP_CLR  = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vs_uir, vs_udr;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_ready, overrun_clr;
  logic        cmd_valid;
  logic [37:0] jdo;
  logic [1:0]  cmd_ir;
  logic [3:0]  take_action;
  logic        ir_update;
  logic [1:0]  ir_latched;
  logic        overrun;
  logic [2:0]  level;

  int nvec  = 0;
  int nfail = 0;

  nios_system_cpu_jtag_cmd_sysclk_fifo dut (
    .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .overrun_clr(overrun_clr),
    .cmd_valid(cmd_valid), .jdo(jdo), .cmd_ir(cmd_ir), .take_action(take_action),
    .ir_update(ir_update), .ir_latched(ir_latched), .overrun(overrun), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          op;
    logic [37:0] sr;
    logic [3:0]  act;
    logic        valid;
    logic [37:0] jdo;
    int          lvl;
    logic        ovr;
  } vec_t;

  vec_t        tbl[10];
  logic [37:0] pat[5];

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic udr_strobe(input logic [37:0] d);
    sr     = d;
    vs_udr = 1'b1;
    cycles(4);
    vs_udr = 1'b0;
    cycles(4);
  endtask

  task automatic pop_one(input string name, input logic [37:0] exp_d);
    chk({name, " valid"}, 64'(cmd_valid), 64'(1));
    chk({name, " jdo"}, 64'(jdo), 64'(exp_d));
    cmd_ready = 1'b1;
    #1;
    chk({name, " act"}, 64'(take_action), 64'(4'b0010));
    cycles(1);
    cmd_ready = 1'b0;
  endtask

  initial begin
    pat[0] = 38'h01_0000_00A1;
    pat[1] = 38'h02_0000_00B2;
    pat[2] = 38'h03_0000_00C3;
    pat[3] = 38'h04_0000_00D4;
    pat[4] = 38'h05_0000_00E5;
`ifdef JTAG_CMD_FIFO_EN
    tbl[0] = '{OP_PUSH, pat[0], 4'b0000, 1'b1, pat[0], 1, 1'b0};
    tbl[1] = '{OP_PUSH, pat[1], 4'b0000, 1'b1, pat[0], 2, 1'b0};
    tbl[2] = '{OP_PUSH, pat[2], 4'b0000, 1'b1, pat[0], 3, 1'b0};
    tbl[3] = '{OP_PUSH, pat[3], 4'b0000, 1'b1, pat[0], 4, 1'b0};
    tbl[4] = '{OP_PUSH, pat[4], 4'b0000, 1'b1, pat[0], 4, 1'b1};
    tbl[5] = '{OP_POP,  38'h0,  4'b0010, 1'b1, pat[1], 3, 1'b1};
    tbl[6] = '{OP_POP,  38'h0,  4'b0010, 1'b1, pat[2], 2, 1'b1};
    tbl[7] = '{OP_POP,  38'h0,  4'b0010, 1'b1, pat[3], 1, 1'b1};
    tbl[8] = '{OP_POP,  38'h0,  4'b0010, 1'b0, 38'h0,  0, 1'b1};
    tbl[9] = '{OP_CLR,  38'h0,  4'b0000, 1'b0, 38'h0,  0, 1'b0};
`else
    tbl[0] = '{OP_PUSH, pat[0], 4'b0000, 1'b1, pat[0], 1, 1'b0};
    tbl[1] = '{OP_PUSH, pat[1], 4'b0000, 1'b1, pat[1], 1, 1'b1};
    tbl[2] = '{OP_PUSH, pat[2], 4'b0000, 1'b1, pat[2], 1, 1'b1};
    tbl[3] = '{OP_PUSH, pat[3], 4'b0000, 1'b1, pat[3], 1, 1'b1};
    tbl[4] = '{OP_PUSH, pat[4], 4'b0000, 1'b1, pat[4], 1, 1'b1};
    tbl[5] = '{OP_POP,  38'h0,  4'b0010, 1'b0, 38'h0,  0, 1'b1};
    tbl[6] = '{OP_POP,  38'h0,  4'b0000, 1'b0, 38'h0,  0, 1'b1};
    tbl[7] = '{OP_POP,  38'h0,  4'b0000, 1'b0, 38'h0,  0, 1'b1};
    tbl[8] = '{OP_POP,  38'h0,  4'b0000, 1'b0, 38'h0,  0, 1'b1};
    tbl[9] = '{OP_CLR,  38'h0,  4'b0000, 1'b0, 38'h0,  0, 1'b0};
`endif

    reset_n = 1'b0; vs_uir = 1'b0; vs_udr = 1'b1; ir_in = 2'b00; sr = 38'h3F_FFFF_FFFF;
    cmd_ready = 1'b0; overrun_clr = 1'b0;
    #1;
    chk("rst valid", 64'(cmd_valid), 64'(0));
    chk("rst jdo", 64'(jdo), 64'(0));
    chk("rst act", 64'(take_action), 64'(0));
    chk("rst ir_latched", 64'(ir_latched), 64'(0));
    chk("rst level", 64'(level), 64'(0));
    chk("rst overrun", 64'(overrun), 64'(0));
    cycles(2);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      chk($sformatf("warm c%0d valid", i), 64'(cmd_valid), 64'(0));
    end
    chk("warm level", 64'(level), 64'(0));
    chk("warm overrun", 64'(overrun), 64'(0));
    vs_udr = 1'b0;
    cycles(4);

    ir_in  = 2'b01;
    vs_uir = 1'b1;
    cycles(2);
    chk("uir pre ir_update", 64'(ir_update), 64'(0));
    cycles(1);
    chk("uir ir_update", 64'(ir_update), 64'(1));
    chk("uir ir_latched", 64'(ir_latched), 64'(1));
    cycles(1);
    chk("uir ir_update end", 64'(ir_update), 64'(0));
    vs_uir = 1'b0;
    ir_in  = 2'b11;
    cycles(4);

    cmd_ready = 1'b1;
    sr        = 38'h2A_DEAD_BEEF;
    vs_udr    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("udr c%0d valid", i), 64'(cmd_valid), 64'(i == 2));
      if (i == 2) begin
        chk("udr jdo", 64'(jdo), 64'(38'h2A_DEAD_BEEF));
        chk("udr cmd_ir", 64'(cmd_ir), 64'(1));
      end
      chk($sformatf("udr c%0d act", i), 64'(take_action), 64'((i == 2) ? 4'b0010 : 4'b0000));
    end
    vs_udr    = 1'b0;
    cmd_ready = 1'b0;
    cycles(4);
    chk("udr drained level", 64'(level), 64'(0));

    for (int i = 0; i < 10; i++) begin
      case (tbl[i].op)
        OP_PUSH: udr_strobe(tbl[i].sr);
        OP_POP: begin
          cmd_ready = 1'b1;
          #1;
          chk($sformatf("vec%0d act", i), 64'(take_action), 64'(tbl[i].act));
          cycles(1);
          cmd_ready = 1'b0;
        end
        default: begin
          overrun_clr = 1'b1;
          cycles(1);
          overrun_clr = 1'b0;
        end
      endcase
      chk($sformatf("vec%0d valid", i), 64'(cmd_valid), 64'(tbl[i].valid));
      chk($sformatf("vec%0d jdo", i), 64'(jdo), 64'(tbl[i].jdo));
      chk($sformatf("vec%0d level", i), 64'(level), 64'(tbl[i].lvl));
      chk($sformatf("vec%0d overrun", i), 64'(overrun), 64'(tbl[i].ovr));
    end

    for (int k = 0; k < DEPTH_EFF; k++) udr_strobe(pat[k]);
    sr     = 38'h15_5555_AAAA;
    vs_udr = 1'b1;
    cycles(2);
    cmd_ready = 1'b1;
    cycles(1);
    cmd_ready = 1'b0;
    chk("fullpop level", 64'(level), 64'(DEPTH_EFF));
    chk("fullpop overrun", 64'(overrun), 64'(0));
    vs_udr = 1'b0;
    cycles(4);
    for (int k = 1; k < DEPTH_EFF; k++) pop_one($sformatf("fullpop drain%0d", k), pat[k]);
    pop_one("fullpop last", 38'h15_5555_AAAA);
    chk("fullpop empty", 64'(cmd_valid), 64'(0));

    for (int k = 0; k < DEPTH_EFF; k++) udr_strobe(pat[k]);
    sr     = 38'h0F_0F0F_0F0F;
    vs_udr = 1'b1;
    cycles(2);
    overrun_clr = 1'b1;
    cycles(1);
    overrun_clr = 1'b0;
    chk("clrdrop overrun", 64'(overrun), 64'(1));
    chk("clrdrop level", 64'(level), 64'(DEPTH_EFF));
    vs_udr = 1'b0;
    cycles(4);
    overrun_clr = 1'b1;
    cycles(1);
    overrun_clr = 1'b0;
    chk("solo clr overrun", 64'(overrun), 64'(0));

    reset_n = 1'b0;
    #1;
    chk("midrst valid", 64'(cmd_valid), 64'(0));
    chk("midrst level", 64'(level), 64'(0));
    chk("midrst ir_latched", 64'(ir_latched), 64'(0));
    cycles(2);
    reset_n = 1'b1;
    cycles(6);
    chk("post rst valid", 64'(cmd_valid), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
